// File: rtl/elevator_motion_ctrl.sv
// Elevator car motion controller: accepts goal-floor requests, enables the
// frequency divider while travelling, steps floors on divided-clock ticks, dwells with door open.
module elevator_motion_ctrl #(
  parameter int FLOORS          = 8,
  parameter int FLOOR_W         = 3,
  parameter int TICKS_PER_FLOOR = 4,
  parameter int DOOR_CYCLES     = 100
) (
  input  logic               clk_50,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_floor,
  output logic               req_ready,
  input  logic               tick,
  output logic               move_en,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               dir_up,
  output logic               door_open,
  output logic               arrived,
  output logic               req_err
);

  localparam int TICK_W = (TICKS_PER_FLOOR > 1) ? $clog2(TICKS_PER_FLOOR) : 1;
  localparam int DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST   = TICK_W'(TICKS_PER_FLOOR - 1);
  localparam logic [DOOR_W-1:0]  DOOR_LAST   = DOOR_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] FLOOR_TOP   = FLOOR_W'(FLOORS - 1);
  localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W + 1)'(FLOORS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [FLOOR_W-1:0]  cur_floor_q, cur_floor_d;
  logic [FLOOR_W-1:0]  goal_q, goal_d;
  logic                dir_up_q, dir_up_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [DOOR_W-1:0]   door_cnt_q, door_cnt_d;
  logic                arrived_q, arrived_d;
  logic                req_err_q, req_err_d;
  logic                sync1_q, sync2_q, sync3_q;
  logic                tick_rise;
  logic [FLOOR_W-1:0]  step_floor;

  // Divided clock is asynchronous to clk_50: two flops for metastability, a third for edge detect.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge values, so the chain shifts one stage per clock.
      sync1_q <= tick;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign tick_rise = sync2_q & ~sync3_q;

  // Saturating guard: a legal goal never drives the car past either end.
  always_comb begin
    step_floor = cur_floor_q;
    if (dir_up_q) begin
      if (cur_floor_q != FLOOR_TOP) step_floor = cur_floor_q + 1'b1;
    end else begin
      if (cur_floor_q != '0) step_floor = cur_floor_q - 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    goal_d      = goal_q;
    dir_up_d    = dir_up_q;
    tick_cnt_d  = tick_cnt_q;
    door_cnt_d  = door_cnt_q;
    arrived_d   = 1'b0;
    req_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if ({1'b0, req_floor} >= FLOOR_LIMIT) begin
            req_err_d = 1'b1;
          end else if (req_floor == cur_floor_q) begin
            state_d   = DOOR;
            arrived_d = 1'b1;
          end else begin
            goal_d     = req_floor;
            dir_up_d   = (req_floor > cur_floor_q);
            tick_cnt_d = '0;
            state_d    = MOVE;
          end
        end
      end
      MOVE: begin
        if (tick_rise) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d  = '0;
            cur_floor_d = step_floor;
            if (step_floor == goal_q) begin
              state_d   = DOOR;
              arrived_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      DOOR: begin
        if (door_cnt_q == DOOR_LAST) begin
          door_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          door_cnt_d = door_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_floor_q <= '0;
      goal_q      <= '0;
      dir_up_q    <= 1'b1;
      tick_cnt_q  <= '0;
      door_cnt_q  <= '0;
      arrived_q   <= 1'b0;
      req_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      goal_q      <= goal_d;
      dir_up_q    <= dir_up_d;
      tick_cnt_q  <= tick_cnt_d;
      door_cnt_q  <= door_cnt_d;
      arrived_q   <= arrived_d;
      req_err_q   <= req_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign move_en   = (state_q == MOVE);
  assign door_open = (state_q == DOOR);
  assign cur_floor = cur_floor_q;
  assign dir_up    = dir_up_q;
  assign arrived   = arrived_q;
  assign req_err   = req_err_q;

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Directed bench for elevator_motion_ctrl: trips up/down, same-floor and
// out-of-range requests, a request held while busy, and reset mid-travel.
module tb_elevator_motion_ctrl;

  localparam int FLOORS  = 8;
  localparam int FLOOR_W = 4;
  localparam int TPF     = 4;
  localparam int DOOR_N  = 100;

  logic               clk_50 = 1'b0;
  logic               rst_n;
  logic               req_valid;
  logic [FLOOR_W-1:0] req_floor;
  logic               req_ready;
  logic               tick;
  logic               move_en;
  logic [FLOOR_W-1:0] cur_floor;
  logic               dir_up;
  logic               door_open;
  logic               arrived;
  logic               req_err;

  int errors = 0;
  int checks = 0;
  int rise_cnt = 0;

  elevator_motion_ctrl #(
    .FLOORS(FLOORS), .FLOOR_W(FLOOR_W), .TICKS_PER_FLOOR(TPF), .DOOR_CYCLES(DOOR_N)
  ) dut (
    .clk_50(clk_50), .rst_n(rst_n), .req_valid(req_valid), .req_floor(req_floor),
    .req_ready(req_ready), .tick(tick), .move_en(move_en), .cur_floor(cur_floor),
    .dir_up(dir_up), .door_open(door_open), .arrived(arrived), .req_err(req_err)
  );

  always #10 clk_50 = ~clk_50;

  // Free-running divided clock: toggles every 10 cycles, one rise per 20.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (10) @(negedge clk_50);
      tick = ~tick;
      if (tick) rise_cnt++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_req(input int floor, input int exp_dir);
    int n = 0;
    req_valid = 1'b1;
    req_floor = FLOOR_W'(floor);
    while (!req_ready && n < 50) begin
      @(negedge clk_50);
      n++;
    end
    check("req_ready_wait", int'(req_ready), 1);
    @(negedge clk_50);
    req_valid = 1'b0;
    check("move_en_after_hs", int'(move_en), 1);
    check("dir_up_after_hs", int'(dir_up), exp_dir);
  endtask

  // Monitors one trip from the handshake cycle through the end of the door dwell.
  task automatic watch_trip(input int start, input int goal);
    int last = start;
    int steps = 0, bad_step = 0, bad_int = 0, arr = 0;
    int move_bad = 0, ready_bad = 0, door_len = 0, door_moves = 0;
    int cyc = 0, rises_at_last = 0;
    bit seen_step = 0;
    forever begin
      if (int'(cur_floor) != last) begin
        if (int'(cur_floor) != ((goal > start) ? last + 1 : last - 1)) bad_step++;
        if (seen_step && (rise_cnt - rises_at_last) != TPF) bad_int++;
        seen_step = 1;
        rises_at_last = rise_cnt;
        last = int'(cur_floor);
        steps++;
      end
      if (arrived) arr++;
      if (door_open || cyc >= 1000) break;
      if (!move_en) move_bad++;
      if (req_ready) ready_bad++;
      @(negedge clk_50);
      cyc++;
    end
    check("trip_timeout", int'(door_open), 1);
    cyc = 0;
    while (door_open && cyc < 500) begin
      door_len++;
      if (int'(cur_floor) != last) door_moves++;
      if (req_ready) ready_bad++;
      @(negedge clk_50);
      cyc++;
      if (arrived) arr++;
    end
    check("step_count", steps, (goal > start) ? goal - start : start - goal);
    check("step_seq", bad_step, 0);
    check("ticks_per_step", bad_int, 0);
    check("final_floor", int'(cur_floor), goal);
    check("arrived_pulses", arr, 1);
    check("move_en_in_move", move_bad, 0);
    check("door_cycles", door_len, DOOR_N);
    check("door_floor_stable", door_moves, 0);
    check("ready_low_busy", ready_bad, 0);
    check("ready_after_door", int'(req_ready), 1);
  endtask

  initial begin
    int n;
    int moves;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_floor = '0;
    repeat (3) @(negedge clk_50);
    rst_n = 1'b1;
    @(negedge clk_50);
    check("rst_cur_floor", int'(cur_floor), 0);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_move_en", int'(move_en), 0);
    check("rst_door_open", int'(door_open), 0);
    check("rst_dir_up", int'(dir_up), 1);
    check("rst_arrived", int'(arrived), 0);

    // 0 -> 3 up, then 3 -> 5 up, then 5 -> 1 down.
    start_req(3, 1);
    watch_trip(0, 3);
    start_req(5, 1);
    watch_trip(3, 5);
    start_req(1, 0);
    watch_trip(5, 1);
    check("down_dir_holds", int'(dir_up), 0);

    // Request for floor 6 held through a 1 -> 3 trip; accepted on first IDLE cycle.
    start_req(3, 1);
    req_valid = 1'b1;
    req_floor = FLOOR_W'(6);
    watch_trip(1, 3);
    @(negedge clk_50);
    check("held_accepted", int'(move_en), 1);
    check("held_dir", int'(dir_up), 1);
    req_valid = 1'b0;
    watch_trip(3, 6);
    moves = 0;
    repeat (20) begin
      @(negedge clk_50);
      if (move_en || door_open) moves++;
    end
    check("single_trip", moves, 0);

    // Reset asserted mid-MOVE at floor 2 on the way down to 0.
    start_req(0, 0);
    n = 0;
    while (cur_floor != FLOOR_W'(2) && n < 1000) begin
      @(negedge clk_50);
      n++;
    end
    check("reach_floor2", int'(cur_floor), 2);
    check("moving_at_2", int'(move_en), 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_cur_floor", int'(cur_floor), 0);
    check("arst_move_en", int'(move_en), 0);
    check("arst_req_ready", int'(req_ready), 1);
    check("arst_dir_up", int'(dir_up), 1);
    repeat (3) @(negedge clk_50);
    check("arst_held_floor", int'(cur_floor), 0);
    rst_n = 1'b1;
    @(negedge clk_50);
    check("post_rst_idle", int'(req_ready), 1);

    // Same-floor request: straight to DOOR, no motion.
    req_valid = 1'b1;
    req_floor = '0;
    @(negedge clk_50);
    req_valid = 1'b0;
    check("same_door", int'(door_open), 1);
    check("same_arrived", int'(arrived), 1);
    moves = int'(move_en);
    n = 0;
    @(negedge clk_50);
    check("same_arrived_drop", int'(arrived), 0);
    while (door_open && n < 500) begin
      if (move_en) moves++;
      @(negedge clk_50);
      n++;
    end
    check("same_no_move", moves, 0);
    check("same_door_len", n + 1, DOOR_N);
    check("same_ready", int'(req_ready), 1);

    // Out-of-range request.
    req_valid = 1'b1;
    req_floor = FLOOR_W'(9);
    @(negedge clk_50);
    req_valid = 1'b0;
    check("err_pulse", int'(req_err), 1);
    check("err_idle", int'(req_ready), 1);
    check("err_no_move", int'(move_en), 0);
    check("err_floor", int'(cur_floor), 0);
    check("err_no_arrive", int'(arrived), 0);
    @(negedge clk_50);
    check("err_pulse_drop", int'(req_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elevator_motion_ctrl.md
Name: elevator_motion_ctrl

Overview:
Car motion controller that drives the enable input of the frequency divider (`frequency`) and consumes its divided `clk` output as a motion tick.
- Accepts a goal-floor request through a valid/ready handshake.
- Asserts `move_en` while travelling and steps the current floor every `TICKS_PER_FLOOR` divided-clock rising edges.
- Opens the door for a fixed number of `clk_50` cycles on arrival, then returns to idle.

Parameters:
- FLOORS, 8, number of floors; valid floors are 0..FLOORS-1.
- FLOOR_W, 3, width of floor fields; must satisfy 2^FLOOR_W >= FLOORS.
- TICKS_PER_FLOOR, 4, divided-clock rising edges per one-floor step; must be >= 1.
- DOOR_CYCLES, 100, `clk_50` cycles the door stays open; must be >= 1.

Ports:
- clk_50  in  1  system clock; all state on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  goal request present.
- req_floor  in  FLOOR_W  requested goal floor.
- req_ready  out  1  controller accepts a request this cycle.
- tick  in  1  divided clock from the frequency divider; treated as asynchronous.
- move_en  out  1  enable to the frequency divider; high only in MOVE.
- cur_floor  out  FLOOR_W  current car floor.
- dir_up  out  1  1 = travelling up, 0 = down; holds the last value outside MOVE.
- door_open  out  1  high in DOOR.
- arrived  out  1  one-cycle pulse on arrival at the goal.
- req_err  out  1  one-cycle pulse when an accepted request has req_floor >= FLOORS.

Behaviour:
- Reset (async assert, sync release) values:
  - state = IDLE, cur_floor = 0, dir_up = 1.
  - move_en = 0, door_open = 0, arrived = 0, req_err = 0, req_ready = 1.
  - All internal counters and sync flops = 0.
- Reset mid-MOVE or mid-DOOR aborts immediately; the car is defined to be at floor 0.
- Tick input path:
  - 2-flop synchroniser, then rising-edge detect: tick_rise = sync2 & ~sync3.
  - Latency from a tick rising edge to tick_rise is 2-3 `clk_50` cycles.
  - tick_rise outside MOVE is ignored.
- The handshake fires on `req_valid & req_ready`. `req_ready` = 1 only in IDLE, combinational from state. A request held while busy is not dropped; it is accepted on the first IDLE cycle.
- FSM, one transition per cycle:
  - IDLE, on handshake:
    - req_floor >= FLOORS: pulse req_err next cycle, stay IDLE.
    - req_floor == cur_floor: go to DOOR and pulse arrived, both in the next cycle; move_en never asserts.
    - Otherwise: latch goal; dir_up = (req_floor > cur_floor); clear tick_cnt; go to MOVE.
  - MOVE: move_en = 1. On each tick_rise:
    - If tick_cnt == TICKS_PER_FLOOR-1: tick_cnt = 0 and cur_floor steps by ±1 per dir_up.
    - Otherwise tick_cnt increments.
    - When the stepped floor equals goal, in the same cycle as the step: next state DOOR, arrived pulses, and move_en drops in the next cycle.
  - DOOR: door_open = 1. door_cnt counts 0..DOOR_CYCLES-1 in `clk_50` cycles, then go to IDLE. The DOOR dwell is exactly DOOR_CYCLES cycles.
- Floor arithmetic:
  - cur_floor never leaves 0..FLOORS-1; there is no wrap-around.
  - A goal is always in range once in MOVE, so saturation logic is a defensive guard only: stepping down at 0 or up at FLOORS-1 holds the value.
- arrived and req_err are registered single-cycle pulses and never coincide.
- tick held high or low indefinitely produces no steps; the car waits in MOVE with move_en = 1 and has no timeout.

Test Plan:
- Reset → cur_floor = 0, req_ready = 1, move_en = 0, door_open = 0. Assert rst_n = 0 for 3 cycles while in MOVE at floor 2 → outputs return to reset values asynchronously.
- Request floor 3 from floor 0, TICKS_PER_FLOOR = 4, with tick toggling every 10 cycles:
  - move_en = 1 the cycle after the handshake, dir_up = 1.
  - cur_floor goes 1, 2, 3, each after 4 tick rises.
  - arrived pulses once; door_open is high for exactly 100 cycles; then req_ready = 1.
- Request floor 5, then floor 1 after arrival → dir_up = 0 on the second trip; cur_floor decrements 5, 4, 3, 2, 1 and stops at 1.
- Request floor 0 while at floor 0 → no move_en; DOOR entered next cycle; arrived pulses once.
- Request floor 9 with FLOORS = 8 → req_err pulses once; state stays IDLE; cur_floor unchanged.
- req_valid held high with floor 6 during MOVE and DOOR of an earlier trip → req_ready stays 0 throughout. The request is accepted on the first IDLE cycle and exactly one new trip starts. Tick edges during DOOR do not change cur_floor.
